// File: rtl/addsub_seq.sv
// Digit-serial unsigned add/subtract. The subtract result is returned as sign plus magnitude.
// A first pass computes a + ~b + 1. A second pass takes the two's complement when the answer is negative.
module addsub_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             sign,
   output logic             carry
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, ADD, NEG, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, sum;
   logic [CW-1:0]    cnt;
   logic             cy, sub_q;

   logic [DIGIT:0]   add_dig, neg_dig;
   logic [WIDTH-1:0] add_next, neg_next;
   logic             last;

   // Each new digit enters sum at the top while sum shifts right.
   // After NDIG steps the word is back in bit order.
   // The NEG pass reuses the same rotation and reads the low digit of sum.
   always_comb begin
      add_dig  = {1'b0, a_sh[DIGIT-1:0]}
               + {1'b0, b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}}}
               + {{DIGIT{1'b0}}, cy};
      neg_dig  = {1'b0, ~sum[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
      add_next = (sum >> DIGIT) | (WIDTH'(add_dig[DIGIT-1:0]) << (WIDTH - DIGIT));
      neg_next = (sum >> DIGIT) | (WIDTH'(neg_dig[DIGIT-1:0]) << (WIDTH - DIGIT));
      last     = (cnt == CW'(NDIG - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         sign      <= 1'b0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum       <= '0;
         cnt       <= '0;
         cy        <= 1'b0;
         sub_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  sub_q    <= sub;
                  cy       <= sub;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ADD;
               end
            end
            ADD: begin
               a_sh <= a_sh >> DIGIT;
               b_sh <= b_sh >> DIGIT;
               sum  <= add_next;
               cy   <= add_dig[DIGIT];
               cnt  <= cnt + 1'b1;
               if (last) begin
                  carry <= add_dig[DIGIT];
                  cnt   <= '0;
                  // No carry out of a subtract means a < b, so the magnitude still has to be negated.
                  if (sub_q && !add_dig[DIGIT]) begin
                     cy    <= 1'b1;
                     state <= NEG;
                  end else begin
                     result    <= add_next;
                     sign      <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            NEG: begin
               sum <= neg_next;
               cy  <= neg_dig[DIGIT];
               cnt <= cnt + 1'b1;
               if (last) begin
                  cnt       <= '0;
                  result    <= neg_next;
                  sign      <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq with three digit widths (1, 4 and 8 bits per clock) on one shared clock and reset.
module tb_addsub_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid [3];
   logic       in_ready [3];
   logic [7:0] a_s [3];
   logic [7:0] b_s [3];
   logic       sub_s [3];
   logic       out_valid [3];
   logic       out_ready [3];
   logic [7:0] res_s [3];
   logic       sign_s [3];
   logic       carry_s [3];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   addsub_seq #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_s[0]), .b(b_s[0]), .sub(sub_s[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .result(res_s[0]), .sign(sign_s[0]), .carry(carry_s[0]));
   addsub_seq #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_s[1]), .b(b_s[1]), .sub(sub_s[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .result(res_s[1]), .sign(sign_s[1]), .carry(carry_s[1]));
   addsub_seq #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a_s[2]), .b(b_s[2]), .sub(sub_s[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .result(res_s[2]), .sign(sign_s[2]), .carry(carry_s[2]));

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until out_valid rises; a timeout returns -1.
   task automatic wait_valid(input int k, output int lat);
      lat = -1;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (out_valid[k]) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input int k, input int av, input int bv, input int sv,
                         input int er, input int es, input int ec, input int el);
      int lat;
      chk({tag, ".in_ready"}, int'(in_ready[k]), 1);
      a_s[k] = 8'(av); b_s[k] = 8'(bv); sub_s[k] = sv[0]; in_valid[k] = 1'b1;
      tick();
      in_valid[k] = 1'b0;
      wait_valid(k, lat);
      chk({tag, ".latency"}, lat, el);
      chk({tag, ".result"}, int'(res_s[k]), er);
      chk({tag, ".sign"}, int'(sign_s[k]), es);
      chk({tag, ".carry"}, int'(carry_s[k]), ec);
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      chk({tag, ".drain_valid"}, int'(out_valid[k]), 0);
      chk({tag, ".drain_ready"}, int'(in_ready[k]), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         a_s[k] = '0; b_s[k] = '0; sub_s[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst.in_ready", int'(in_ready[k]), 1);
         chk("rst.out_valid", int'(out_valid[k]), 0);
         chk("rst.result", int'(res_s[k]), 0);
         chk("rst.sign_carry", int'({sign_s[k], carry_s[k]}), 0);
      end
      rst_n = 1'b1;

      // DIGIT = 1
      run_op("d1_add_200_100", 0, 200, 100, 0, 44, 0, 1, 8);
      run_op("d1_sub_5_9",     0, 5,   9,   1, 4,  1, 0, 16);
      run_op("d1_sub_9_9",     0, 9,   9,   1, 0,  0, 1, 8);
      run_op("d1_add_255_1",   0, 255, 1,   0, 0,  0, 1, 8);
      run_op("d1_sub_0_255",   0, 0,   255, 1, 255, 1, 0, 16);
      // DIGIT = 4
      run_op("d4_sub_9_9",     1, 9,   9,   1, 0,  0, 1, 2);
      run_op("d4_sub_0_255",   1, 0,   255, 1, 255, 1, 0, 4);
      run_op("d4_add_200_100", 1, 200, 100, 0, 44, 0, 1, 2);
      run_op("d4_sub_100_37",  1, 100, 37,  1, 63, 0, 1, 2);
      // DIGIT = WIDTH
      run_op("d8_sub_5_9",     2, 5,   9,   1, 4,  1, 0, 2);
      run_op("d8_add_128_128", 2, 128, 128, 0, 0,  0, 1, 1);
      run_op("d8_sub_200_55",  2, 200, 55,  1, 145, 0, 1, 1);

      // Hold in DONE with in_valid and operands toggling underneath.
      a_s[0] = 8'd10; b_s[0] = 8'd20; sub_s[0] = 1'b0; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      wait_valid(0, lat);
      chk("hold.latency", lat, 8);
      for (int i = 0; i < 5; i++) begin
         in_valid[0] = ~in_valid[0];
         a_s[0] = 8'(i * 37 + 1); b_s[0] = 8'(i * 11 + 3); sub_s[0] = i[0];
         tick();
         chk("hold.result", int'(res_s[0]), 30);
         chk("hold.flags", int'({out_valid[0], in_ready[0], sign_s[0], carry_s[0]}), 4'b1000);
      end
      a_s[0] = 8'd7; b_s[0] = 8'd1; sub_s[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      chk("hold.exit_valid", int'(out_valid[0]), 0);
      chk("hold.exit_ready", int'(in_ready[0]), 1);
      tick();
      in_valid[0] = 1'b0;
      chk("hold.accept_ready", int'(in_ready[0]), 0);
      wait_valid(0, lat);
      chk("hold.next_latency", lat, 8);
      chk("hold.next_result", int'(res_s[0]), 6);
      chk("hold.next_carry", int'(carry_s[0]), 1);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;

      // Asynchronous reset in the middle of ADD.
      a_s[0] = 8'd3; b_s[0] = 8'd7; sub_s[0] = 1'b1; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.result", int'(res_s[0]), 0);
      chk("midrst.sign_carry", int'({sign_s[0], carry_s[0]}), 0);
      chk("midrst.out_valid", int'(out_valid[0]), 0);
      chk("midrst.in_ready", int'(in_ready[0]), 1);
      tick();
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid[0]) lat++;
      end
      chk("midrst.no_valid", lat, 0);
      run_op("post_rst_add_1_2", 0, 1, 2, 0, 3, 0, 0, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (>=2).
REQ-002 SHALL have parameter DIGIT, default 1, meaning bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT; NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands and mode are presented.
REQ-006 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL have port a  input  WIDTH  unsigned minuend/addend.
REQ-008 SHALL have port b  input  WIDTH  unsigned subtrahend/addend.
REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid  output  1  result, sign and carry are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  WIDTH  magnitude of the result.
REQ-013 SHALL have port sign  output  1  1 = result is negative (subtract only).
REQ-014 SHALL have port carry  output  1  carry-out of the first-pass addition.

Function
REQ-015 SHALL implement FSM states IDLE, ADD, NEG, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an operation is accepted on a rising edge with in_valid=1 and in_ready=1, capturing a, b and sub.
REQ-017 in_valid SHALL be ignored in ADD, NEG and DONE; no operand or state change results.
REQ-018 ADD SHALL run NDIG cycles, LSB digit first, computing a + (b XOR {WIDTH{sub}}) + sub, DIGIT bits per cycle, with a one-bit carry register between digits.
REQ-019 After the last ADD digit: carry SHALL register the final carry-out; if sub=1 and carry=0, next state is NEG, else next state is DONE.
REQ-020 NEG SHALL run NDIG cycles, replacing the stored sum with its two's complement (invert, add 1 serially LSB first); sign SHALL be set to 1.
REQ-021 Add mode: result = (a+b) mod 2^WIDTH, carry = 1 iff a+b >= 2^WIDTH, sign = 0.
REQ-022 Subtract, a >= b: result = a-b, carry = 1, sign = 0; a == b gives result 0, sign 0, carry 1.
REQ-023 Subtract, a < b: result = b-a, carry = 0, sign = 1.
REQ-024 out_valid SHALL rise exactly NDIG rising edges after the accepting edge when no correction is needed, and exactly 2*NDIG edges after it when NEG runs.
REQ-025 In DONE, out_valid = 1; result, sign and carry SHALL hold stable until the edge where out_ready = 1, after which state = IDLE and out_valid = 0.
REQ-026 Back-to-back: a new operation SHALL be accepted no earlier than the edge after the DONE-to-IDLE transition.
REQ-027 result, sign and carry SHALL be registered outputs; result holds its last value in IDLE.
REQ-028 All widths SHALL be handled without truncation of the internal carry; DIGIT = WIDTH SHALL give single-cycle ADD and NEG phases.

Reset
REQ-029 rst_n = 0 SHALL immediately force state IDLE, in_ready = 1, out_valid = 0, result = 0, sign = 0, carry = 0, and clear the digit counter and internal carry.
REQ-030 Reset asserted during ADD, NEG or DONE SHALL abort the operation; no out_valid follows release of reset.
REQ-031 The first operation SHALL be accepted on the first rising edge with rst_n = 1 and in_valid = 1.

Verification
REQ-032 WIDTH=8, DIGIT=1: add a=200, b=100 -> result=44, carry=1, sign=0; out_valid rises 8 edges after accept.
REQ-033 WIDTH=8, DIGIT=1: sub a=5, b=9 -> result=4, sign=1, carry=0; out_valid rises 16 edges after accept.
REQ-034 WIDTH=8, DIGIT=4: sub a=9, b=9 -> result=0, sign=0, carry=1 after 2 edges; sub a=0, b=255 -> result=255, sign=1 after 4 edges.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> outputs and out_valid unchanged, in_ready=0; operation accepted only after the DONE-to-IDLE edge.
REQ-036 Assert rst_n=0 mid-ADD (sub a=3, b=7) -> all outputs zero at once, in_ready=1; after release, add a=1, b=2 -> result=3, sign=0, carry=0.
